// File: rtl/memoria_m_pkg.sv
// Shared constants, word type and content function for the memoria_m ROM.
// Used by memoria_m_array (table) and memoria_m (output registers).
package memoria_m_pkg;

    localparam int unsigned AW_DEF = 11;
    localparam int unsigned DW_DEF = 8;

    typedef logic [DW_DEF-1:0] word_t;

    // Every word repeats the low address nibble, so contents alias every 16 addresses.
    function automatic word_t rom_word(input int unsigned addr);
        logic [3:0] nib;
        nib = 4'(addr);
        return {nib, nib};
    endfunction

endpackage

// File: rtl/memoria_m_array.sv
// Combinational ROM table of 2**AW words, filled from memoria_m_pkg::rom_word.
module memoria_m_array
    import memoria_m_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    logic [DW-1:0] rom [2**AW];

    for (genvar i = 0; i < 2**AW; i++) begin : g_rom
        assign rom[i] = DW'(rom_word(i));
    end

    assign data = rom[addr];

endmodule

// File: rtl/memoria_m.sv
// Read-only memory with registered output and synchronous reset.
// Define MEMORIA_M_OREG_EN to add a second output register (2-cycle latency).
module memoria_m
    import memoria_m_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          iclk,
    input  logic          irst,
    input  logic [AW-1:0] ivadress,
    output logic [DW-1:0] ovdata
);

    logic [DW-1:0] rd_data;
    logic [DW-1:0] stage1_q;

    memoria_m_array #(
        .AW(AW),
        .DW(DW)
    ) u_array (
        .addr(ivadress),
        .data(rd_data)
    );

    always_ff @(posedge iclk) begin
        if (irst) begin
            stage1_q <= '0;
        end else begin
            stage1_q <= rd_data;
        end
    end

`ifdef MEMORIA_M_OREG_EN
    logic [DW-1:0] stage2_q;

    always_ff @(posedge iclk) begin
        if (irst) begin
            stage2_q <= '0;
        end else begin
            stage2_q <= stage1_q;
        end
    end

    assign ovdata = stage2_q;
`else
    assign ovdata = stage1_q;
`endif

endmodule

// File: tb/tb_memoria_m.sv
// Directed self-checking bench for memoria_m; latency follows MEMORIA_M_OREG_EN.
module tb_memoria_m;

`ifdef MEMORIA_M_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        iclk = 1'b0;
    logic        irst;
    logic [10:0] ivadress;
    logic [7:0]  ovdata;

    int n_checks = 0;
    int n_fail   = 0;

    memoria_m u_dut (
        .iclk    (iclk),
        .irst    (irst),
        .ivadress(ivadress),
        .ovdata  (ovdata)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [10:0] a);
        @(negedge iclk);
        irst     = rst;
        ivadress = a;
    endtask

    task automatic edge_sample();
        @(posedge iclk);
        #1;
    endtask

    logic [10:0] alias_addr [3] = '{11'h010, 11'h3A7, 11'h7FF};
    logic [7:0]  alias_exp  [3] = '{8'h00, 8'h77, 8'hFF};
    logic [10:0] b2b_addr   [5] = '{11'h001, 11'h002, 11'h003, 11'h003, 11'h003};
    logic [7:0]  b2b_exp    [5] = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33};

    initial begin
        irst     = 1'b1;
        ivadress = 11'h005;
        edge_sample();
        edge_sample();
        check("reset", ovdata, 8'h00);

        // Sweep 0x000..0x00F, each held 8 cycles
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 11'(a));
            for (int k = 0; k < 8; k++) begin
                edge_sample();
                if (k >= LAT - 1) check($sformatf("sweep_%0h_%0d", a, k), ovdata, 8'(a * 17));
            end
        end

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, alias_addr[i]);
            edge_sample();
            edge_sample();
            edge_sample();
            check($sformatf("alias_%03h", alias_addr[i]), ovdata, alias_exp[i]);
        end

        // Previous output is 0xFF from address 0x7FF
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, b2b_addr[i]);
            edge_sample();
            if (i - (LAT - 1) < 0) check($sformatf("b2b_%0d", i), ovdata, 8'hFF);
            else check($sformatf("b2b_%0d", i), ovdata, b2b_exp[i-(LAT-1)]);
        end

        drive(1'b1, 11'h009);
        edge_sample();
        check("rst_mid", ovdata, 8'h00);
        drive(1'b0, 11'h009);
        for (int k = 0; k < LAT; k++) begin
            edge_sample();
            check($sformatf("rst_rel_%0d", k), ovdata, (k == LAT - 1) ? 8'h99 : 8'h00);
        end

        drive(1'b0, 11'h00C);
        for (int k = 0; k < 20; k++) begin
            edge_sample();
            if (k >= LAT - 1) begin
                check($sformatf("hold_%0d", k), ovdata, 8'hCC);
                #3;
                check($sformatf("hold_mid_%0d", k), ovdata, 8'hCC);
            end
        end

        // Last address to 0 wraps without special handling
        drive(1'b0, 11'h7FF);
        for (int k = 0; k < LAT; k++) edge_sample();
        check("wrap_last", ovdata, 8'hFF);
        drive(1'b0, 11'h000);
        for (int k = 0; k < LAT; k++) edge_sample();
        check("wrap_zero", ovdata, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
